// File: rtl/sdrahb_sync_fifo.sv
// Single-clock synchronous FIFO on an inferred simple dual-port RAM with registered read.
// Level-decoded status flags, sticky overflow/underflow, and a synchronous flush.
module sdrahb_sync_fifo #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clr,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_level,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LVL_W = ADDR_WIDTH + 1;
   localparam logic [LVL_W-1:0]      LVL_DEPTH  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]      LVL_AFULL  = LVL_W'(AFULL_THRESH);
   localparam logic [LVL_W-1:0]      LVL_AEMPTY = LVL_W'(AEMPTY_THRESH);
   localparam logic [LVL_W-1:0]      LVL_ONE    = LVL_W'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [LVL_W-1:0]      r_level;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_rd_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_wr_acc;
   logic w_rd_acc;

   // Flags come only from the registered level, so there is no comb path from the requests.
   assign w_full   = (r_level == LVL_DEPTH);
   assign w_empty  = (r_level == '0);
   assign w_wr_acc = i_wr_en & ~w_full & ~i_clr;
   assign w_rd_acc = i_rd_en & ~w_empty & ~i_clr;

   // RAM array is kept free of reset so it can map onto block memory.
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= i_data_in;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_data_out  <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (i_clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            r_data_out <= r_mem[r_rd_ptr];
         end
         r_rd_valid <= w_rd_acc;
         if (w_wr_acc && !w_rd_acc) begin
            r_level <= r_level + LVL_ONE;
         end else if (!w_wr_acc && w_rd_acc) begin
            r_level <= r_level - LVL_ONE;
         end
         if (i_wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (i_rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign o_data_out     = r_data_out;
   assign o_rd_valid     = r_rd_valid;
   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_level >= LVL_AFULL);
   assign o_almost_empty = (r_level <= LVL_AEMPTY);
   assign o_level        = r_level;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sdrahb_sync_fifo.sv
// Directed bench for sdrahb_sync_fifo: a vector table for basic traffic plus hand-written
// sequences for fill/drain, error flags, pointer wrap, flush and asynchronous reset.
module tb_sdrahb_sync_fifo;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic          wr;
   logic          rd;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          rdValid;
   logic          full;
   logic          empty;
   logic          almostFull;
   logic          almostEmpty;
   logic [AW:0]   level;
   logic          overflow;
   logic          underflow;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic          c;
      logic          w;
      logic          r;
      logic [DW-1:0] d;
      int            lvl;
      logic          rdv;
      logic [DW-1:0] dout;
      logic          ovf;
      logic          udf;
   } vec_t;

   vec_t vecs[14];

   sdrahb_sync_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_THRESH(12),
      .AEMPTY_THRESH(2)
   ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_clr(clr),
      .i_wr_en(wr),
      .i_data_in(din),
      .i_rd_en(rd),
      .o_data_out(dout),
      .o_rd_valid(rdValid),
      .o_full(full),
      .o_empty(empty),
      .o_almost_full(almostFull),
      .o_almost_empty(almostEmpty),
      .o_level(level),
      .o_overflow(overflow),
      .o_underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int id, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s #%0d got=0x%0h want=0x%0h", tag, id, act, exp);
      end
   endtask

   // Status flags are derived here from the expected level, independent of the DUT.
   task automatic checkState(input int id, input int lvl, input logic rdv, input logic [DW-1:0] expDout,
                             input logic ovf, input logic udf);
      logic expFull;
      logic expEmpty;
      logic expAf;
      logic expAe;
      expFull  = (lvl == DEPTH);
      expEmpty = (lvl == 0);
      expAf    = (lvl >= 12);
      expAe    = (lvl <= 2);
      checkOutput("level", id, 32'(level), lvl);
      checkOutput("full", id, 32'(full), 32'(expFull));
      checkOutput("empty", id, 32'(empty), 32'(expEmpty));
      checkOutput("almost_full", id, 32'(almostFull), 32'(expAf));
      checkOutput("almost_empty", id, 32'(almostEmpty), 32'(expAe));
      checkOutput("rd_valid", id, 32'(rdValid), 32'(rdv));
      checkOutput("data_out", id, dout, expDout);
      checkOutput("overflow", id, 32'(overflow), 32'(ovf));
      checkOutput("underflow", id, 32'(underflow), 32'(udf));
   endtask

   // Drive inputs on the falling edge, let one rising edge happen, sample on the next falling edge.
   task automatic applyStimulus(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      clr = c;
      wr  = w;
      rd  = r;
      din = d;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      wr  = 1'b0;
      rd  = 1'b0;
   endtask

   task automatic doReset(input int id);
      rst = 1'b1;
      @(negedge clk);
      checkState(id, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      wr  = 1'b0;
      rd  = 1'b0;
      din = '0;

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h11, 1, 1'b0, 32'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h22, 2, 1'b0, 32'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h33, 3, 1'b0, 32'h00, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h00, 2, 1'b1, 32'h11, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h00, 2, 1'b0, 32'h11, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h44, 2, 1'b1, 32'h22, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 32'h33, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 32'h44, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h44, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h55, 1, 1'b0, 32'h44, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h66, 0, 1'b0, 32'h44, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h66, 1, 1'b0, 32'h44, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h44, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b0, 32'h44, 1'b0, 1'b1};

      @(negedge clk);
      doReset(0);

      $display("[TB] vector table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].d);
         checkState(100 + i, vecs[i].lvl, vecs[i].rdv, vecs[i].dout, vecs[i].ovf, vecs[i].udf);
      end

      $display("[TB] fill, overflow, drain, underflow, flush");
      doReset(200);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, DW'(i));
         checkState(210 + i, i + 1, 1'b0, 32'h0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hDEAD);
      checkState(230, 16, 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState(231, 16, 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hBEEF);
      checkState(232, 15, 1'b1, 32'h0, 1'b1, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
         checkState(240 + i, 15 - i, 1'b1, DW'(i), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkState(260, 0, 1'b0, 32'hF, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
      checkState(261, 1, 1'b0, 32'hF, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkState(262, 0, 1'b0, 32'hF, 1'b0, 1'b0);

      $display("[TB] steady level 8 across pointer wrap");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, DW'(100 + k));
         checkState(300 + k, k + 1, 1'b0, 32'hF, 1'b0, 1'b0);
      end
      for (int c = 0; c < 40; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, DW'(108 + c));
         checkState(310 + c, 8, 1'b1, DW'(100 + c), 1'b0, 1'b0);
      end

      $display("[TB] async reset mid-burst");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkState(400, 0, 1'b0, DW'(139), 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, DW'(32'h200 + k));
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkState(401, 5, 1'b1, 32'h200, 1'b0, 1'b0);
      wr  = 1'b1;
      din = 32'h1234;
      rst = 1'b1;
      #1;
      checkState(402, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkState(403, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      wr  = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
      checkState(404, 1, 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkState(405, 0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkState(406, 0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
